fsk_frame_encoder: RTL and testbench
====================================

# fsk_frame_encoder

Parametrised serial frame encoder for the FSK transmit path. It accepts a DATA_W-bit word over a valid/ready handshake. It emits a framed bit stream: a sync pattern, then one Hamming(7,4) codeword per data nibble, each bit held for BIT_CYC clocks. Its output drives the FSK modulator's bit input, and it supports back-to-back frames with no idle gap.

## Interface
- DATA_W, 8: payload width; multiple of 4, ≥4; NIB = DATA_W/4 codewords per frame.
- SYNC_LEN, 3: sync pattern length in bits, ≥1.
- SYNC_PAT, 3'b110: sync pattern, SYNC_LEN bits, sent MSB first.
- BIT_CYC, 1: clocks per output bit, ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  DATA_W  payload word; sampled only on handshake.
- in_valid  in  1  data_in valid.
- in_ready  out  1  encoder can accept a word this cycle.
- data_out  out  1  serial frame bit; 0 when idle.
- busy  out  1  a frame is being emitted.
- frame_done  out  1  one-cycle pulse on the final clock of a frame.

## Operation
- Frame bit count: N = SYNC_LEN + 7·NIB, plus 1 when FSK_ENC_FRAME_PARITY_EN is defined.
- Frame order:
  - Sync: SYNC_PAT, MSB first.
  - Codewords: for each nibble from the most significant, d3 d2 d1 d0 p1 p2 p3, where p1=d3^d2^d1, p2=d3^d2^d0, p3=d3^d1^d0.
  - Optional parity bit last.
- States:
  - IDLE: data_out=0, busy=0, in_ready=1.
  - SYNC, DATA: emit bits; a bit counter advances every BIT_CYC clocks.
  - PAR: present only with the macro.
- IDLE→SYNC on handshake (in_valid && in_ready at the clock edge). data_in is latched into a shift register. Later changes on data_in do not affect the frame.
- After the last bit:
  - If a handshake occurs in the frame's final cycle, go to SYNC with the new word.
  - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (final cycle of frame). It is 0 at all other times during a frame.
- in_valid while in_ready=0 is ignored. No word is lost or queued; the source must hold it.
- Async reset mid-frame: return to IDLE immediately, discard the frame, emit no frame_done.

## Timing
- Reset values: data_out=0, in_ready=1, busy=0, frame_done=0. All internal counters are 0.
- Handshake at edge T: at T+1, busy=1 and data_out=SYNC_PAT[SYNC_LEN-1].
- Bit k (0-based) is valid on cycles T+1+k·BIT_CYC through T+(k+1)·BIT_CYC.
- frame_done=1 and in_ready=1 on cycle T+N·BIT_CYC only.
- Frame duration is exactly N·BIT_CYC cycles.
- Back-to-back frames: the next frame's first sync bit appears at T+N·BIT_CYC+1, with no gap and busy held at 1.
- Without a back-to-back handshake, at T+N·BIT_CYC+1: busy=0, data_out=0.
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid to data_out.

## Configuration
- FSK_ENC_FRAME_PARITY_EN defined: one extra bit after the last codeword. It is the even parity of all 7·NIB codeword bits, so the XOR of codeword bits and parity bit is 0. N grows by 1.
- FSK_ENC_FRAME_PARITY_EN undefined: the frame ends after the last p3. There is no PAR state and no parity logic.

## Test plan
- Reset/idle (defaults, BIT_CYC=4, macro undefined): assert rst_n low, release, hold in_valid=0 for 20 cycles → data_out=0, busy=0, in_ready=1, frame_done=0 throughout.
- Single frame (defaults, BIT_CYC=4, macro undefined), data_in=8'hA5:
  - Bits are 110 1010010 0101101 (17 bits), each held 4 clocks.
  - frame_done pulses exactly once, 68 cycles after the handshake.
  - busy returns to 0 on the next cycle.
- Parity (same setup, macro defined, data_in=8'hA5): an 18th bit equal to 1 follows 0101101. The frame lasts 72 cycles.
- Back-to-back (defaults, BIT_CYC=1): hold in_valid=1 with 8'h00, then 8'hFF.
  - Second handshake lands on the frame_done cycle.
  - 8'h00 frame: 110 0000000 0000000; 8'hFF frame: 110 1111111 1111111.
  - The frames are contiguous, busy never drops, frame_done pulses twice.
- Stall/ignore: change data_in and pulse in_valid while busy=1 → in_ready=0, the emitted frame matches the originally latched word, and no extra frame is produced.
- Reset mid-frame: assert rst_n at bit 9 of an 8'hA5 frame → outputs go to reset values immediately, there is no frame_done, and a new 8'h3C frame afterwards is correct: 110 0011110 1100001.

Source files
------------

// File: rtl/fsk_frame_encoder.sv
// Serial FSK frame encoder: sync pattern followed by Hamming(7,4) codewords, each bit held BIT_CYC clocks.
// Define FSK_ENC_FRAME_PARITY_EN to append an even-parity bit over all codeword bits.
module fsk_frame_encoder #(
  parameter int                  DATA_W   = 8,
  parameter int                  SYNC_LEN = 3,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = 3'b110,
  parameter int                  BIT_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int NIB    = DATA_W / 4;
  localparam int CW_END = SYNC_LEN + 7 * NIB;
`ifdef FSK_ENC_FRAME_PARITY_EN
  localparam int N      = CW_END + 1;
`else
  localparam int N      = CW_END;
`endif
  localparam int BCW    = $clog2(N);
  localparam int CCW    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     fr;
  logic [BCW-1:0]   bit_cnt;
  logic [CCW-1:0]   cyc_cnt;
  logic             bit_end, final_cyc, hs;

  // The whole frame is assembled at handshake and shifted out MSB first.
  function automatic logic [N-1:0] build_frame(input logic [DATA_W-1:0] d);
    logic [N-1:0]      f;
    logic [DATA_W-1:0] w;
    logic [3:0]        n;
    logic [6:0]        cw;
`ifdef FSK_ENC_FRAME_PARITY_EN
    logic              p;
    p = 1'b0;
`endif
    f = N'(SYNC_PAT);
    w = d;
    for (int i = 0; i < NIB; i++) begin
      n  = w[DATA_W-1 -: 4];
      w  = w << 4;
      cw = {n, n[3] ^ n[2] ^ n[1], n[3] ^ n[2] ^ n[0], n[3] ^ n[1] ^ n[0]};
      f  = (f << 7) | N'(cw);
`ifdef FSK_ENC_FRAME_PARITY_EN
      p  = p ^ (^cw);
`endif
    end
`ifdef FSK_ENC_FRAME_PARITY_EN
    f = (f << 1) | N'(p);
`endif
    return f;
  endfunction

  assign bit_end   = (cyc_cnt == CCW'(BIT_CYC - 1));
  assign final_cyc = (state != IDLE) && bit_end && (bit_cnt == BCW'(N - 1));
  assign hs        = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (hs) state_nxt = SYNC;
      SYNC: if (bit_end && bit_cnt == BCW'(SYNC_LEN - 1)) state_nxt = DATA;
      DATA: if (bit_end && bit_cnt == BCW'(CW_END - 1))
`ifdef FSK_ENC_FRAME_PARITY_EN
              state_nxt = PAR;
      PAR:  if (bit_end) state_nxt = hs ? SYNC : IDLE;
`else
              state_nxt = hs ? SYNC : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    data_out   = (state != IDLE) && fr[N-1];
    frame_done = final_cyc;
    in_ready   = (state == IDLE) || final_cyc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fr      <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else if (hs) begin
      fr      <= build_frame(data_in);
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else if (state_nxt == IDLE) begin
      fr      <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else if (bit_end) begin
      fr      <= {fr[N-2:0], 1'b0};
      bit_cnt <= bit_cnt + 1'b1;
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fsk_frame_encoder.sv
// Directed bench for fsk_frame_encoder: one instance at BIT_CYC=4, one at BIT_CYC=1.
module tb_fsk_frame_encoder;

`ifdef FSK_ENC_FRAME_PARITY_EN
  localparam int N = 18;
  localparam logic [N-1:0] EXP_A5 = {17'b110_1010010_0101101, 1'b1};
  localparam logic [N-1:0] EXP_00 = {17'b110_0000000_0000000, 1'b0};
  localparam logic [N-1:0] EXP_FF = {17'b110_1111111_1111111, 1'b0};
  localparam logic [N-1:0] EXP_3C = {17'b110_0011110_1100001, 1'b1};
`else
  localparam int N = 17;
  localparam logic [N-1:0] EXP_A5 = 17'b110_1010010_0101101;
  localparam logic [N-1:0] EXP_00 = 17'b110_0000000_0000000;
  localparam logic [N-1:0] EXP_FF = 17'b110_1111111_1111111;
  localparam logic [N-1:0] EXP_3C = 17'b110_0011110_1100001;
`endif
  localparam int BC = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] din4 = '0, din1 = '0;
  logic       vld4 = 1'b0, vld1 = 1'b0;
  logic       rdy4, do4, busy4, fd4;
  logic       rdy1, do1, busy1, fd1;

  int total = 0, bad = 0;
  logic obs_do [1:200];
  logic obs_bz [1:200];
  logic obs_fd [1:200];
  logic obs_rd [1:200];

  always #5 clk = ~clk;

  fsk_frame_encoder #(.DATA_W(8), .SYNC_LEN(3), .SYNC_PAT(3'b110), .BIT_CYC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(din4), .in_valid(vld4), .in_ready(rdy4),
    .data_out(do4), .busy(busy4), .frame_done(fd4));

  fsk_frame_encoder #(.DATA_W(8), .SYNC_LEN(3), .SYNC_PAT(3'b110), .BIT_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din1), .in_valid(vld1), .in_ready(rdy1),
    .data_out(do1), .busy(busy1), .frame_done(fd1));

  task automatic start4(input logic [7:0] d);
    @(negedge clk);
    din4 = d;
    vld4 = 1'b1;
    @(posedge clk);
    #1 vld4 = 1'b0;
  endtask

  task automatic capture4(input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      obs_do[c] = do4; obs_bz[c] = busy4; obs_fd[c] = fd4; obs_rd[c] = rdy4;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; vld4 = 1'b0; vld1 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({do4, busy4, rdy4, fd4} !== 4'b0010) begin
      bad++; $display("FAIL reset_hold: got do/busy/rdy/fd=%b want 0010", {do4, busy4, rdy4, fd4});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if ({do4, busy4, rdy4, fd4, do1, busy1, rdy1, fd1} !== 8'b0010_0010) begin
        bad++; $display("FAIL idle cyc%0d: got %b want 00100010", c, {do4, busy4, rdy4, fd4, do1, busy1, rdy1, fd1});
      end
    end
  endtask

  task automatic test_single_frame;
    start4(8'hA5);
    din4 = 8'h00;
    capture4(N * BC + 1);
    for (int c = 1; c <= N * BC; c++) begin
      total++;
      if ({obs_do[c], obs_bz[c], obs_fd[c], obs_rd[c]} !==
          {EXP_A5[N-1-(c-1)/BC], 1'b1, (c == N * BC), (c == N * BC)}) begin
        bad++; $display("FAIL single cyc%0d: got do/busy/fd/rdy=%b%b%b%b want %b1%b%b", c, obs_do[c], obs_bz[c],
                        obs_fd[c], obs_rd[c], EXP_A5[N-1-(c-1)/BC], (c == N * BC), (c == N * BC));
      end
    end
    total++;
    if ({obs_do[N*BC+1], obs_bz[N*BC+1], obs_fd[N*BC+1], obs_rd[N*BC+1]} !== 4'b0001) begin
      bad++; $display("FAIL single_after: got do/busy/fd/rdy=%b%b%b%b want 0001", obs_do[N*BC+1],
                      obs_bz[N*BC+1], obs_fd[N*BC+1], obs_rd[N*BC+1]);
    end
  endtask

  task automatic test_back_to_back;
    int  nfd;
    logic e;
    nfd = 0;
    @(negedge clk);
    din1 = 8'h00;
    vld1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 2 * N; c++) begin
      @(negedge clk);
      e = (c <= N) ? EXP_00[N-c] : EXP_FF[2*N-c];
      if (fd1) nfd++;
      total++;
      if ({do1, busy1, fd1} !== {e, 1'b1, (c == N || c == 2 * N)}) begin
        bad++; $display("FAIL b2b cyc%0d: got do/busy/fd=%b%b%b want %b1%b", c, do1, busy1, fd1, e, (c == N || c == 2 * N));
      end
      if (c == N) begin
        total++;
        if (rdy1 !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", rdy1); end
      end
      if (c == 1) din1 = 8'hFF;
      if (c == 2 * N) vld1 = 1'b0;
    end
    @(negedge clk);
    total++;
    if ({do1, busy1, nfd} !== {2'b00, 32'd2}) begin
      bad++; $display("FAIL b2b_end: got do=%b busy=%b pulses=%0d want 0 0 2", do1, busy1, nfd);
    end
  endtask

  task automatic test_stall;
    start4(8'hA5);
    for (int c = 1; c <= N * BC; c++) begin
      @(negedge clk);
      obs_do[c] = do4; obs_rd[c] = rdy4;
      if (c >= 3 && c <= 30) begin vld4 = c[0]; din4 = 8'hFF ^ c[7:0]; end
      else vld4 = 1'b0;
    end
    for (int c = 1; c <= N * BC; c++) begin
      total++;
      if ({obs_do[c], obs_rd[c]} !== {EXP_A5[N-1-(c-1)/BC], (c == N * BC)}) begin
        bad++; $display("FAIL stall cyc%0d: got do/rdy=%b%b want %b%b", c, obs_do[c], obs_rd[c],
                        EXP_A5[N-1-(c-1)/BC], (c == N * BC));
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({busy4, fd4} !== 2'b00) begin bad++; $display("FAIL stall_extra cyc%0d: got busy/fd=%b%b want 00", c, busy4, fd4); end
    end
  endtask

  task automatic test_reset_mid;
    start4(8'hA5);
    repeat (9 * BC + 1) @(negedge clk);
    total++;
    if ({do4, busy4} !== {EXP_A5[N-10], 1'b1}) begin
      bad++; $display("FAIL mid_bit9: got do/busy=%b%b want %b1", do4, busy4, EXP_A5[N-10]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({do4, busy4, rdy4, fd4} !== 4'b0010) begin
      bad++; $display("FAIL mid_reset: got do/busy/rdy/fd=%b want 0010", {do4, busy4, rdy4, fd4});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if ({busy4, fd4} !== 2'b00) begin bad++; $display("FAIL mid_after cyc%0d: got busy/fd=%b%b want 00", c, busy4, fd4); end
    end
    start4(8'h3C);
    capture4(N * BC);
    for (int c = 1; c <= N * BC; c++) begin
      total++;
      if ({obs_do[c], obs_fd[c]} !== {EXP_3C[N-1-(c-1)/BC], (c == N * BC)}) begin
        bad++; $display("FAIL frame3c cyc%0d: got do/fd=%b%b want %b%b", c, obs_do[c], obs_fd[c],
                        EXP_3C[N-1-(c-1)/BC], (c == N * BC));
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
